// File: rtl/nibble_serial_adder_pkg.sv
// Shared constants for the nibble-serial adder: slice width, FSM encoding
// and the nibble-counter width helper.
package nibble_serial_adder_pkg;

   localparam int NIBBLE_W = 4;

   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] RUN  = 2'b01;
   localparam logic [1:0] DONE = 2'b10;

   // Counter must index nibbles 0..n-1; keep at least one bit.
   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/nibble_serial_adder_rca.sv
// Existing 4-bit ripple-carry adder slice, purely combinational.
module RCA_4bit (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);

   always_comb begin
      logic c;
      c   = cin;
      sum = '0;
      for (int i = 0; i < 4; i++) begin
         sum[i] = a[i] ^ b[i] ^ c;
         c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      cout = c;
   end

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide adder that reuses one RCA_4bit slice, processing one nibble per clock
// from LSB to MSB with the carry held in a register between cycles.
module nibble_serial_adder
   import nibble_serial_adder_pkg::*;
#(
   parameter int NIBBLES = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [NIBBLE_W*NIBBLES-1:0] in_a,
   input  logic [NIBBLE_W*NIBBLES-1:0] in_b,
   input  logic                      in_cin,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [NIBBLE_W*NIBBLES-1:0] out_sum,
   output logic                      out_cout,
   output logic                      busy
);

   localparam int W     = NIBBLE_W * NIBBLES;
   localparam int CNT_W = cnt_width(NIBBLES);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

   // Handshakes: a transfer happens on a rising edge where valid and ready
   // are both high; valid never depends combinationally on ready.
   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic [W-1:0]     a_sh_q, a_sh_d;
   logic [W-1:0]     b_sh_q, b_sh_d;
   logic [W-1:0]     res_q, res_d;
   logic [W-1:0]     out_sum_q, out_sum_d;
   logic             out_cout_q, out_cout_d;
   logic             out_valid_q, out_valid_d;
   logic             in_ready_q, in_ready_d;

   logic [NIBBLE_W-1:0] slice_sum;
   logic                slice_cout;
   logic [W-1:0]        res_next;

   RCA_4bit u_slice (
      .a    (a_sh_q[NIBBLE_W-1:0]),
      .b    (b_sh_q[NIBBLE_W-1:0]),
      .cin  (carry_q),
      .sum  (slice_sum),
      .cout (slice_cout)
   );

   // Each new sum nibble enters at the top, so after NIBBLES shifts the
   // first nibble has reached bit 0.
   assign res_next = {slice_sum, res_q[W-1:NIBBLE_W]};

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      carry_d     = carry_q;
      a_sh_d      = a_sh_q;
      b_sh_d      = b_sh_q;
      res_d       = res_q;
      out_sum_d   = out_sum_q;
      out_cout_d  = out_cout_q;
      out_valid_d = out_valid_q;
      in_ready_d  = in_ready_q;
      case (state_q)
         IDLE: begin
            in_ready_d = 1'b1;
            if (in_valid && in_ready_q) begin
               a_sh_d     = in_a;
               b_sh_d     = in_b;
               carry_d    = in_cin;
               cnt_d      = '0;
               in_ready_d = 1'b0;
               state_d    = RUN;
            end
         end
         RUN: begin
            res_d   = res_next;
            a_sh_d  = a_sh_q >> NIBBLE_W;
            b_sh_d  = b_sh_q >> NIBBLE_W;
            carry_d = slice_cout;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == LAST) begin
               out_sum_d   = res_next;
               out_cout_d  = slice_cout;
               out_valid_d = 1'b1;
               state_d     = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = IDLE;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            in_ready_d  = 1'b0;
            state_d     = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         carry_q     <= 1'b0;
         a_sh_q      <= '0;
         b_sh_q      <= '0;
         res_q       <= '0;
         out_sum_q   <= '0;
         out_cout_q  <= 1'b0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         carry_q     <= carry_d;
         a_sh_q      <= a_sh_d;
         b_sh_q      <= b_sh_d;
         res_q       <= res_d;
         out_sum_q   <= out_sum_d;
         out_cout_q  <= out_cout_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_sum   = out_sum_q;
   assign out_cout  = out_cout_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed plus random bench for nibble_serial_adder; expected sums come from
// plain wide integer addition.
module tb_nibble_serial_adder;

   localparam int N = 4;
   localparam int W = 4 * N;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_cin = 1'b0;
   logic         out_ready = 1'b0;
   logic [W-1:0] in_a = '0;
   logic [W-1:0] in_b = '0;
   logic         in_ready;
   logic         out_valid;
   logic [W-1:0] out_sum;
   logic         out_cout;
   logic         busy;

   int           checks = 0;
   int           failures = 0;
   logic [W:0]   last_exp = '0;

   nibble_serial_adder #(.NIBBLES(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_cin    (in_cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic cin);
      return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
   endfunction

   // Present operands, let them be accepted, scramble the inputs, then wait
   // for the result and compare against the reference sum.
   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
      int cyc;
      @(negedge clk);
      chk("ready_before_accept", in_ready, 1);
      in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_a = W'($urandom); in_b = W'($urandom); in_cin = 1'($urandom_range(0, 1));
      last_exp = ref_add(a, b, cin);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
         if (!out_valid && cyc < N + 1) chk("busy_run", busy, 1);
      end while (!out_valid && cyc < 40);
      chk("latency", W'(cyc), W'(N + 1));
      chk("sum", out_sum, {1'b0, last_exp[W-1:0]});
      chk("cout", out_cout, {{W{1'b0}}, last_exp[W]});
      chk("ready_in_done", in_ready, 0);
   endtask

   task automatic ack_op();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      chk("valid_after_ack", out_valid, 0);
      chk("ready_after_ack", in_ready, 1);
      chk("busy_after_ack", busy, 0);
      chk("result_retained", {out_cout, out_sum}, last_exp);
   endtask

   initial begin
      logic [W-1:0] held;
      int           t;

      // Reset held with a pending request.
      in_valid = 1'b1; in_a = 16'hABCD; in_b = 16'h1234;
      repeat (3) begin
         @(negedge clk);
         chk("rst_in_ready", in_ready, 0);
         chk("rst_out_valid", out_valid, 0);
         chk("rst_out_sum", out_sum, 0);
         chk("rst_out_cout", out_cout, 0);
         chk("rst_busy", busy, 0);
      end
      rst_n = 1'b1;
      in_valid = 1'b0;
      chk("ready_at_release", in_ready, 0);
      @(negedge clk);
      chk("ready_first_edge", in_ready, 1);

      // Directed cases.
      start_op(16'h1234, 16'h4321, 1'b0); ack_op();
      start_op(16'hFFFF, 16'h0001, 1'b0); ack_op();
      start_op(16'hFFFF, 16'h0000, 1'b1); ack_op();
      start_op(16'h0F0F, 16'h00F1, 1'b1); ack_op();
      start_op(16'h8000, 16'h8000, 1'b0); ack_op();

      // Backpressure: result held while new requests are ignored.
      start_op(16'h0ACE, 16'h1357, 1'b1);
      held = out_sum;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         in_valid = ~in_valid;
         in_a = W'($urandom); in_b = W'($urandom);
         chk("bp_valid", out_valid, 1);
         chk("bp_sum_stable", out_sum, {1'b0, held});
         chk("bp_in_ready", in_ready, 0);
      end
      in_valid = 1'b0;
      ack_op();

      // Reset during the second RUN cycle discards the operation.
      @(negedge clk);
      in_a = 16'h1111; in_b = 16'h2222; in_cin = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_valid", out_valid, 0);
      chk("midrst_ready", in_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      t = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (out_valid) t++;
      end
      chk("midrst_no_pulse", W'(t), 0);
      start_op(16'h0001, 16'h0002, 1'b0); ack_op();

      // Random operands.
      for (int i = 0; i < 12; i++) begin
         start_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 3)) @(negedge clk);
         ack_op();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
Multi-cycle wide adder that feeds the existing RCA_4bit combinational slice one nibble per clock and consumes its sum/cout.
- Accepts two 4*NIBBLES-bit operands plus carry-in over a valid/ready handshake.
- Ripples the carry through a carry register across NIBBLES cycles.
- Presents the full-width sum and final carry-out on a valid/ready output.
- Sits between operand sources and result consumers that need adds wider than 4 bits without replicating adder hardware.

Parameters:
NIBBLES, 4, number of 4-bit slices; operand width = 4*NIBBLES (default 16 bits); legal range 2..16.

Ports:
clk  input  1  single clock, rising-edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  operand request.
in_ready  output  1  block can accept operands; registered.
in_a  input  4*NIBBLES  operand A.
in_b  input  4*NIBBLES  operand B.
in_cin  input  1  carry-in to the least-significant nibble.
out_valid  output  1  result available.
out_ready  input  1  consumer accepts result.
out_sum  output  4*NIBBLES  A + B + cin, modulo 2^(4*NIBBLES).
out_cout  output  1  carry out of the most-significant nibble.
busy  output  1  high whenever state is not IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE; in_ready=0; out_valid=0; out_sum=0; out_cout=0; busy=0; carry register and nibble counter cleared.
- in_ready goes to 1 on the first rising edge with rst_n high.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid&in_ready: latch in_a/in_b into shift registers, carry<=in_cin, count<=0, in_ready<=0, go to RUN.
- RUN:
  - The RCA_4bit slice is driven with a=A[3:0], b=B[3:0], cin=carry (combinational).
  - Each edge: sum nibble shifts into the MSB end of the result register; A and B shift right by 4; carry<=slice cout; count++.
  - On the edge where count==NIBBLES-1 commits: out_sum<=full result, out_cout<=slice cout, out_valid<=1, go to DONE.
- DONE:
  - out_valid held at 1; out_sum and out_cout held stable.
  - On an edge with out_ready=1: out_valid<=0, in_ready<=1, go to IDLE.
  - out_sum and out_cout keep their last value after the handshake; they are not cleared.
- Latency: handshake at edge E0; out_valid first high in the cycle after edge E0+NIBBLES, i.e. NIBBLES+1 cycles after the accepting cycle.
- Throughput: one operation per NIBBLES+2 cycles minimum. No overlap of input acceptance with RUN or DONE.
- in_valid while busy: ignored; operands are not sampled.
- out_ready while not in DONE: ignored.
- Wrap-around: result is modulo 2^(4*NIBBLES); overflow is reported only via out_cout.
- Reset asserted mid-operation (RUN or DONE): immediate return to reset values. The in-flight operation is discarded and no out_valid pulse is produced.
- in_a/in_b may change freely after acceptance; the result depends only on the latched values.

Decomposition:
- Shared package:
  - NIBBLE_W=4.
  - State encoding constants IDLE=2'b00, RUN=2'b01, DONE=2'b10.
  - Counter width derived as clog2(NIBBLES).
- Sub-module: one instance of the existing RCA_4bit as the per-cycle adder slice. All sequencing, shift registers and the carry register live in nibble_serial_adder.

Test Plan:
1. Reset: hold rst_n low 3 cycles with in_valid=1 -> in_ready=0, out_valid=0, out_sum=0, out_cout=0, busy=0. After release, in_ready=1 at the next edge, then accept.
2. Latency/normal: in_a=0x1234, in_b=0x4321, in_cin=0 -> out_sum=0x5555, out_cout=0. out_valid rises exactly 5 cycles after the accepting cycle (NIBBLES=4).
3. Full carry ripple: 0xFFFF + 0x0001, cin=0 -> out_sum=0x0000, out_cout=1. Repeat with 0xFFFF + 0x0000, cin=1 -> same result.
4. Mixed carry: 0x0F0F + 0x00F1, cin=1 -> out_sum=0x1001, out_cout=0. Then 0x8000 + 0x8000, cin=0 -> out_sum=0x0000, out_cout=1.
5. Backpressure: hold out_ready=0 for 10 cycles in DONE while toggling in_valid with new operands -> out_valid stays 1, out_sum stable, in_ready stays 0, new operands not taken. Raise out_ready -> IDLE, in_ready=1 next cycle.
6. Mid-operation reset: pulse rst_n low during the 2nd RUN cycle of 0x1111 + 0x2222 -> busy=0 and no out_valid. The next operation, 0x0001 + 0x0002, gives 0x0003, cout=0.
